// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state codes and
// the iteration counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter must reach WIDTH without wrapping.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Control FSM and iteration counter for shift_add_mult.
// With MULT_EARLY_TERM_EN defined, RUN ends as soon as the multiplier is exhausted.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          start,
    input  logic                          mplr_zero,
    output logic [1:0]                    v,
    output logic                          busy,
    output logic                          done,
    output logic                          load,
    output logic                          step,
    output logic [cnt_bits(WIDTH)-1:0]    cnt
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          stop_early;

`ifdef MULT_EARLY_TERM_EN
    assign stop_early = mplr_zero;
`else
    assign stop_early = 1'b0;
    logic  unused_mplr_zero;
    assign unused_mplr_zero = mplr_zero;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = cnt;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = stop_early ? DONE : RUN;
                end
            end
            RUN: begin
                step      = 1'b1;
                cnt_nxt   = cnt + CW'(1);
                state_nxt = (cnt == LAST_CNT || stop_early) ? DONE : RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign v    = state;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per cycle.
// Optional MULT_EARLY_TERM_EN stops as soon as no set multiplier bits remain.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           v
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplr;
    logic [CW-1:0]      cnt;
    logic               load;
    logic               step;
    logic               mplr_zero;
    logic               last_step;

    mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .mplr_zero (mplr_zero),
        .v         (v),
        .busy      (busy),
        .done      (done),
        .load      (load),
        .step      (step),
        .cnt       (cnt)
    );

    // Outside RUN this flags b==0 for the accepting edge; in RUN it looks at
    // the multiplier as it will be after this cycle's shift.
    assign mplr_zero = busy ? (mplr[WIDTH-1:1] == '0) : (b == '0);
    assign acc_nxt   = mplr[0] ? acc + mcand : acc;

`ifdef MULT_EARLY_TERM_EN
    assign last_step = step && (cnt == LAST_CNT || mplr_zero);
`else
    assign last_step = step && (cnt == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
        end else if (load) begin
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            acc   <= '0;
        end else if (step) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
        end
    end

    // product only changes on entry to DONE, so it holds through the next RUN.
    always_ff @(posedge clk) begin
        if (clr) begin
            product <= '0;
        end else if (last_step) begin
            product <= acc_nxt;
`ifdef MULT_EARLY_TERM_EN
        end else if (load && mplr_zero) begin
            product <= '0;
`endif
        end
    end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request a multiply; sampled on clk rising edge.
REQ-005 The block SHALL have port a  input  WIDTH  multiplicand, unsigned; sampled only when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  multiplier, unsigned; sampled only when start is accepted.
REQ-007 The block SHALL have port product  output  2*WIDTH  registered result of the last completed multiply.
REQ-008 The block SHALL have port busy  output  1  high while the FSM is in state RUN.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; product is valid in that cycle.
REQ-010 The block SHALL have port v  output  2  current FSM state code.

Function
REQ-011 The FSM SHALL have three states: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 SHALL return to IDLE on the next edge.
REQ-012 The block SHALL accept start only in IDLE or DONE; in RUN, start is ignored and a/b are not sampled.
REQ-013 On acceptance the block SHALL load mcand={WIDTH'b0,a}, mplr=b, acc=0, cnt=0, and go to RUN.
REQ-014 Each RUN cycle SHALL do: if mplr[0] then acc+=mcand (2*WIDTH bits, no overflow possible); mcand<<=1; mplr>>=1; cnt+=1.
REQ-015 RUN SHALL last exactly WIDTH cycles; on the last cycle the block SHALL go to DONE.
REQ-016 On entry to DONE, product SHALL be loaded with the final acc, i.e. a*b.
REQ-017 product SHALL hold its value at all other times, including during the next RUN.
REQ-018 done SHALL be high exactly in DONE; busy SHALL be high exactly in RUN.
REQ-019 In DONE, if start=1 the block SHALL go to RUN (back-to-back operation); otherwise it SHALL go to IDLE.
REQ-020 Latency SHALL be WIDTH+1 cycles from the accepting edge to the edge at which done first samples high.
REQ-021 cnt SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within one operation.

Reset
REQ-022 When clr=1 at an edge, the block SHALL set state=IDLE, product=0, acc=0, mcand=0, mplr=0, and cnt=0.
REQ-023 After that edge, done=0, busy=0, and v=2'b00.
REQ-024 clr SHALL take priority over start and SHALL abort a RUN in progress with no done pulse.
REQ-025 The first edge with clr=0 and start=1 SHALL be accepted normally.

Configuration
REQ-026 Macro MULT_EARLY_TERM_EN, when defined, SHALL make RUN go to DONE in any cycle where the updated mplr (after the shift) equals 0.
REQ-027 When MULT_EARLY_TERM_EN is defined, an accepted start with b=0 SHALL go directly to DONE with product=0 (latency 1).
REQ-028 When MULT_EARLY_TERM_EN is defined, latency SHALL be 1 + (index of the highest set bit of b) + 1.
REQ-029 When MULT_EARLY_TERM_EN is not defined, RUN SHALL always last WIDTH cycles.
REQ-030 The product value SHALL be identical in both builds.

Structure
REQ-031 Package mult_pkg SHALL hold the state encoding constants IDLE, RUN, and DONE.
REQ-032 Package mult_pkg SHALL hold a function for the cnt width.
REQ-033 The FSM and counter SHALL be in sub-module mult_ctrl, with inputs clk, clr, start, and mplr_zero.
REQ-034 mult_ctrl SHALL drive v, busy, done, load, step, and cnt.
REQ-035 The shift/add datapath SHALL stay in shift_add_mult.

Verification
REQ-036 Test WIDTH=4: a=13, b=11, start for 1 cycle -> busy for 4 cycles, then done for 1 cycle with product=143, then v=00.
REQ-037 Test WIDTH=4: a=15, b=15 -> product=225.
REQ-038 Test WIDTH=4: a=0, b=9 -> product=0 with full latency 5.
REQ-039 Test back-to-back: 15*15 with start held high through DONE, then a=2, b=3 -> done pulses 5 cycles apart, products 225 then 6.
REQ-040 Test reset mid-operation: start 13*11, assert clr in the 2nd RUN cycle -> v=00, product=0, no done pulse; a following 3*5 -> product=15.
REQ-041 Test WIDTH=8: a=255, b=255 -> product=65025, latency 9.
REQ-042 Test MULT_EARLY_TERM_EN with WIDTH=8: a=200, b=1 -> done at latency 2, product=200.
REQ-043 Test MULT_EARLY_TERM_EN with b=0 -> done at latency 1, product=0.
